// File: rtl/ltssm_detect_poll_ctrl.sv
// Link-training front end: Detect.Quiet/Active, Polling.Active/Configuration/Compliance, Config hand-off.
// Per-lane receiver-detect handshake, per-lane TS receive counting, TS transmit counting and lane narrowing.
module ltssm_detect_poll_ctrl #(
  parameter int LANE_NUM       = 4,
  parameter int CNT_W          = 32,
  parameter int DET_QUIET_TO   = 12000,
  parameter int DET_ACTIVE_TO  = 12000,
  parameter int POLL_ACTIVE_TO = 24000,
  parameter int POLL_CFG_TO    = 48000,
  parameter int TS_RX_MIN      = 8,
  parameter int TS_TX_MIN      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANE_NUM-1:0] elec_idle_break,
  output logic [LANE_NUM-1:0] rx_det_seq_req,
  input  logic [LANE_NUM-1:0] rx_det_seq_ack,
  input  logic [LANE_NUM-1:0] rx_det_valid,
  input  logic                force_compliance,
  input  logic                link_down,
  output logic [7:0]          ts_info,
  output logic                ts_start,
  input  logic                ts_sent,
  input  logic [LANE_NUM-1:0] ts1_rx,
  input  logic [LANE_NUM-1:0] ts2_rx,
  output logic [LANE_NUM-1:0] lane_active,
  output logic                link_up,
  output logic                timeout_evt
);

  typedef enum logic [2:0] {S_DQ, S_DA, S_PA, S_PC, S_PCOMP, S_CFG} state_t;

  localparam int RX_W = $clog2(TS_RX_MIN + 1);
  localparam int TX_W = $clog2(TS_TX_MIN + 1);
  localparam logic [RX_W-1:0] RX_FULL = RX_W'(TS_RX_MIN);
  localparam logic [TX_W-1:0] TX_FULL = TX_W'(TS_TX_MIN);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    timer;
  logic                fresh;
  logic                timed, expire, acked_all, train_ok, state_chg, ts2_seen;
  logic [LANE_NUM-1:0] acked, rx_qual, lane_nxt;
  logic [RX_W-1:0]     rx_cnt [LANE_NUM];
  logic [TX_W-1:0]     tx_cnt;

  function automatic logic [7:0] ts_code(input state_t s);
    case (s)
      S_DA:    return 8'h01;
      S_PA:    return 8'h10;
      S_PC:    return 8'h11;
      S_PCOMP: return 8'h12;
      S_CFG:   return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] timeout_load(input state_t s);
    case (s)
      S_DQ:    return CNT_W'(DET_QUIET_TO - 1);
      S_DA:    return CNT_W'(DET_ACTIVE_TO - 1);
      S_PA:    return CNT_W'(POLL_ACTIVE_TO - 1);
      S_PC:    return CNT_W'(POLL_CFG_TO - 1);
      default: return '0;
    endcase
  endfunction

  // The first cycle out of reset only loads the timer, so it can never expire there.
  always_comb begin
    timed     = (state == S_DQ) || (state == S_DA) || (state == S_PA) || (state == S_PC);
    expire    = timed && !fresh && (timer == '0);
    acked_all = &(acked | rx_det_seq_ack);
    rx_qual   = '0;
    for (int i = 0; i < LANE_NUM; i++) begin
      rx_qual[i] = lane_active[i] && (rx_cnt[i] == RX_FULL);
    end
    train_ok  = (rx_qual == lane_active) && (tx_cnt == TX_FULL);
  end

  always_comb begin
    state_nxt = state;
    lane_nxt  = lane_active;
    case (state)
      S_DQ: begin
        if (|elec_idle_break || expire) state_nxt = S_DA;
      end
      S_DA: begin
        if (acked_all) begin
          if (|rx_det_valid) begin
            state_nxt = S_PA;
            lane_nxt  = rx_det_valid;
          end else begin
            state_nxt = S_DQ;
          end
        end else if (expire) begin
          state_nxt = S_DQ;
        end
      end
      S_PA: begin
        if (force_compliance) begin
          state_nxt = S_PCOMP;
        end else if (train_ok) begin
          state_nxt = S_PC;
        end else if (expire) begin
          state_nxt = (|rx_qual) ? S_PC : S_DQ;
          lane_nxt  = rx_qual;
        end
      end
      S_PCOMP: begin
        if (!force_compliance) state_nxt = S_PA;
      end
      S_PC: begin
        if (train_ok)    state_nxt = S_CFG;
        else if (expire) state_nxt = S_DQ;
      end
      S_CFG: begin
        if (link_down) state_nxt = S_DQ;
      end
      default: state_nxt = S_DQ;
    endcase
    if (state_nxt == S_DQ) lane_nxt = '0;
    state_chg = (state_nxt != state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_DQ;
      timer          <= '0;
      fresh          <= 1'b1;
      lane_active    <= '0;
      rx_det_seq_req <= '0;
      acked          <= '0;
      ts_info        <= 8'h00;
      ts_start       <= 1'b0;
      link_up        <= 1'b0;
      timeout_evt    <= 1'b0;
      tx_cnt         <= '0;
      ts2_seen       <= 1'b0;
      for (int i = 0; i < LANE_NUM; i++) rx_cnt[i] <= '0;
    end else begin
      state       <= state_nxt;
      lane_active <= lane_nxt;
      fresh       <= 1'b0;
      ts_info     <= ts_code(state_nxt);
      ts_start    <= state_chg;
      link_up     <= (state_nxt == S_CFG);
      timeout_evt <= expire;

      if (state_chg)      timer <= timeout_load(state_nxt);
      else if (fresh)     timer <= timeout_load(state);
      else if (timer != '0) timer <= timer - CNT_W'(1);

      if (state_chg) begin
        rx_det_seq_req <= (state_nxt == S_DA) ? '1 : '0;
        acked          <= '0;
      end else if (state == S_DA) begin
        rx_det_seq_req <= rx_det_seq_req & ~rx_det_seq_ack;
        acked          <= acked | rx_det_seq_ack;
      end

      // Pulses in a transition cycle would only bump counters that are cleared on entry anyway.
      for (int i = 0; i < LANE_NUM; i++) begin
        if (state_chg) begin
          rx_cnt[i] <= '0;
        end else if (lane_active[i] && state == S_PA) begin
          if ((ts1_rx[i] || ts2_rx[i]) && rx_cnt[i] != RX_FULL) rx_cnt[i] <= rx_cnt[i] + RX_W'(1);
        end else if (lane_active[i] && state == S_PC) begin
          if (ts2_rx[i]) begin
            if (rx_cnt[i] != RX_FULL) rx_cnt[i] <= rx_cnt[i] + RX_W'(1);
          end else if (ts1_rx[i]) begin
            rx_cnt[i] <= '0;
          end
        end
      end

      if (state_chg) begin
        tx_cnt   <= '0;
        ts2_seen <= 1'b0;
      end else begin
        if (ts_sent && tx_cnt != TX_FULL && (state == S_PA || (state == S_PC && ts2_seen)))
          tx_cnt <= tx_cnt + TX_W'(1);
        if (state == S_PC && |(ts2_rx & lane_active)) ts2_seen <= 1'b1;
      end
    end
  end

endmodule
